wind_vane_adc_responder: RTL and testbench
==========================================

// Module: wind_vane_adc_responder
// PURPOSE
//  Synthesizable SPI responder (slave) model of the wind-vane ADC: the far end of the SPICLK/nVaneCS/MISO link.
//  Samples SPICLK/nVaneCS in the Clock domain and shifts a 16-bit frame MSB-first on MISO.
//  Used in the weather_core top-level bench and for FPGA emulation in place of the real ADC.
//  SPI mode: SPICLK idles high; MISO changes after SPICLK falls; the initiator samples on SPICLK rise.
// PARAMETERS
//  DATA_BITS    12  ADC code width; frame = {LEAD_BITS zeros, null 0, code[DATA_BITS-1:0]}
//  FRAME_BITS   16  SPICLK cycles per frame; LEAD_BITS = FRAME_BITS-DATA_BITS-1 (=3)
//  SYNC_STAGES  2   flip-flop synchroniser depth on SPICLK and nVaneCS
// PORTS
//  Clock         in   1   system clock
//  nReset        in   1   asynchronous, active-low reset
//  SPICLK        in   1   SPI clock from the initiator (asynchronous to Clock)
//  nVaneCS       in   1   chip select, active low (asynchronous to Clock)
//  vane_code     in   12  ADC code to return; latched when nVaneCS falls
//  MISO          out  1   serial data to the initiator
//  MISO_nEnable  out  1   0 = MISO driven (frame active); 1 = MISO released
//  frame_done    out  1   1-Clock pulse on the FRAME_BITS-th SPICLK rise
//  frame_abort   out  1   1-Clock pulse when nVaneCS rises before frame_done
//  bit_count     out  5   SPICLK rises counted in the current frame (saturates at 31)
// BEHAVIOUR
//  Reset: MISO=0, MISO_nEnable=1, frame_done=0, frame_abort=0, bit_count=0, state=IDLE, sync regs=1 (idle levels).
//  Edge detection: compare the last sync stage with one extra register.
//  A pin edge is acted on at the 3rd Clock rise after it (SYNC_STAGES+1).
//  Each SPICLK half-period must be >= 4 Clock periods; shorter pulses are undefined behaviour.
//  FSM states: IDLE, SHIFT, TRAIL.
//   IDLE  -> SHIFT on CS fall:
//     - shreg <= frame built from vane_code; MISO <= frame[15] (=0); MISO_nEnable <= 0; bit_count <= 0.
//   SHIFT, on SPICLK fall:
//     - shift left, fill 0; MISO <= new MSB.
//   SHIFT, on SPICLK rise:
//     - bit_count++.
//     - When the count reaches FRAME_BITS: pulse frame_done, go to TRAIL.
//   TRAIL: MISO <= 0 on every SPICLK fall; bit_count keeps counting, saturating at 31.
//   SHIFT/TRAIL -> IDLE on CS rise:
//     - MISO_nEnable <= 1; MISO <= 0.
//     - frame_abort pulses only if leaving SHIFT.
//  SPICLK edges in IDLE are ignored; bit_count holds its last value until the next CS fall.
//  Simultaneous events (same detect cycle):
//   - CS fall + SPICLK fall: load the frame only; the clock edge is ignored.
//   - CS rise + SPICLK rise: count the rise first.
//     If this completes the frame, pulse frame_done (not frame_abort), then go to IDLE.
//  vane_code changes during a frame are not seen until the next CS fall.
//  Asynchronous reset mid-frame: immediate return to reset values.
//   A following CS fall starts a clean frame.
//   A CS already low at reset release produces no frame (no fall is seen).
// STRUCTURE
//  weather_pkg additions:
//   - typedef enum logic [1:0] {VANE_IDLE, VANE_SHIFT, VANE_TRAIL} vane_state_t
//   - VANE_FRAME_BITS=16, VANE_DATA_BITS=12
//  Sub-module: sync_edge_detect (SYNC_STAGES synchroniser + rise/fall pulses), instanced for SPICLK and nVaneCS.
//  The remainder (FSM, shift register, counter) stays in this module.
// TESTING
//  1 vane_code=12'hA5C, 16 SPICLK cycles at 9 ms/9 ms (Demo timing) -> bits read on rises = 16'h0A5C;
//    one frame_done; bit_count=16; MISO_nEnable=1 after CS rise.
//  2 vane_code=12'hFFF then 12'h000 in back-to-back frames -> 16'h0FFF then 16'h0000; no frame_abort.
//  3 CS rises after 8 SPICLK rises -> frame_abort pulse, bit_count=8, MISO_nEnable=1, no frame_done.
//  4 vane_code changed 12'h123 -> 12'h456 after bit 5 -> frame reads 16'h0123; the next frame reads 16'h0456.
//  5 18 SPICLK cycles -> rises 17-18 read 0; bit_count=18; exactly one frame_done.
//  6 nReset pulsed low mid-frame (after 6 rises) -> outputs at reset values at once;
//    the next CS fall gives a full correct frame.

Source files
------------

// File: rtl/wind_vane_adc_responder_pkg.sv
// Shared types and frame constants for the wind-vane ADC SPI responder.
package wind_vane_adc_responder_pkg;

  typedef enum logic [1:0] {VANE_IDLE, VANE_SHIFT, VANE_TRAIL} vane_state_t;

  localparam int VANE_FRAME_BITS  = 16;
  localparam int VANE_DATA_BITS   = 12;
  localparam int VANE_SYNC_STAGES = 2;
  localparam int VANE_CNT_BITS    = 5;

endpackage

// File: rtl/wind_vane_adc_responder_sync.sv
// Pin synchroniser with one-cycle rise/fall pulses taken from the last sync stage.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;
  logic [STAGES:0]   r_arm;
  logic              w_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_last <= 1'b1;
      r_arm  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_last <= r_sync[STAGES-1];
      r_arm  <= {r_arm[STAGES-1:0], 1'b1};
    end
  end

  // A pin already low when reset releases must not look like a fresh edge.
  assign w_armed = r_arm[STAGES];
  assign o_rise  = w_armed &  r_sync[STAGES-1] & ~r_last;
  assign o_fall  = w_armed & ~r_sync[STAGES-1] &  r_last;

endmodule

// File: rtl/wind_vane_adc_responder.sv
// SPI responder model of the wind-vane ADC: shifts {zeros, null, code} MSB-first on MISO.
module wind_vane_adc_responder
  import wind_vane_adc_responder_pkg::*;
#(
  parameter int DATA_BITS   = VANE_DATA_BITS,
  parameter int FRAME_BITS  = VANE_FRAME_BITS,
  parameter int SYNC_STAGES = VANE_SYNC_STAGES
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     SPICLK,
  input  logic                     nVaneCS,
  input  logic [DATA_BITS-1:0]     vane_code,
  output logic                     MISO,
  output logic                     MISO_nEnable,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic [VANE_CNT_BITS-1:0] bit_count
);

  localparam int LEAD_BITS = FRAME_BITS - DATA_BITS - 1;
  localparam logic [VANE_CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [VANE_CNT_BITS-1:0] CNT_LAST = VANE_CNT_BITS'(FRAME_BITS - 1);

  logic                     w_clk_rise;
  logic                     w_clk_fall;
  logic                     w_cs_rise;
  logic                     w_cs_fall;
  logic [FRAME_BITS-1:0]    w_frame;
  logic                     w_completing;

  vane_state_t              r_state;
  logic [FRAME_BITS-1:0]    r_shreg;
  logic                     r_miso;
  logic                     r_nen;
  logic                     r_done;
  logic                     r_abort;
  logic [VANE_CNT_BITS-1:0] r_cnt;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_spiclk (
    .i_clk   (Clock),
    .i_rst_n (nReset),
    .i_pin   (SPICLK),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk   (Clock),
    .i_rst_n (nReset),
    .i_pin   (nVaneCS),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_frame      = {{LEAD_BITS{1'b0}}, 1'b0, vane_code};
  assign w_completing = (r_state == VANE_SHIFT) && w_clk_rise && (r_cnt == CNT_LAST);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= VANE_IDLE;
      r_shreg <= '0;
      r_miso  <= 1'b0;
      r_nen   <= 1'b1;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        VANE_IDLE: begin
          // A SPICLK fall coinciding with CS fall is deliberately dropped here.
          if (w_cs_fall) begin
            r_shreg <= w_frame;
            r_miso  <= w_frame[FRAME_BITS-1];
            r_nen   <= 1'b0;
            r_cnt   <= '0;
            r_state <= VANE_SHIFT;
          end
        end
        VANE_SHIFT, VANE_TRAIL: begin
          if (w_clk_rise) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (w_completing) begin
              r_done  <= 1'b1;
              r_state <= VANE_TRAIL;
            end
          end else if (w_clk_fall) begin
            if (r_state == VANE_SHIFT) begin
              r_shreg <= {r_shreg[FRAME_BITS-2:0], 1'b0};
              r_miso  <= r_shreg[FRAME_BITS-2];
            end else begin
              r_miso  <= 1'b0;
            end
          end
          // CS rise overrides the state move above; a rise that completes the frame still counts.
          if (w_cs_rise) begin
            r_nen   <= 1'b1;
            r_miso  <= 1'b0;
            r_state <= VANE_IDLE;
            if ((r_state == VANE_SHIFT) && !w_completing) r_abort <= 1'b1;
          end
        end
        default: r_state <= VANE_IDLE;
      endcase
    end
  end

  assign MISO         = r_miso;
  assign MISO_nEnable = r_nen;
  assign frame_done   = r_done;
  assign frame_abort  = r_abort;
  assign bit_count    = r_cnt;

endmodule

// File: tb/tb_wind_vane_adc_responder.sv
// Directed bench for the wind-vane ADC responder acting as the SPI initiator.
module tb_wind_vane_adc_responder;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        SPICLK = 1'b1;
  logic        nVaneCS = 1'b1;
  logic [11:0] vane_code = 12'h000;
  logic        MISO;
  logic        MISO_nEnable;
  logic        frame_done;
  logic        frame_abort;
  logic [4:0]  bit_count;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  localparam int HALF = 8;

  wind_vane_adc_responder dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .SPICLK       (SPICLK),
    .nVaneCS      (nVaneCS),
    .vane_code    (vane_code),
    .MISO         (MISO),
    .MISO_nEnable (MISO_nEnable),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .bit_count    (bit_count)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // CS and SPICLK drop together; MISO is read just before each SPICLK rise.
  task automatic do_frame(input logic [11:0] code, input int nclk, input bit raise_cs,
                          input int change_at, input logic [11:0] code2,
                          output logic [15:0] rd, output logic nen_mid);
    rd = 16'h0000;
    vane_code = code;
    wait_clk(2);
    nVaneCS = 1'b0;
    SPICLK  = 1'b0;
    wait_clk(HALF);
    nen_mid = MISO_nEnable;
    for (int i = 0; i < nclk; i++) begin
      if (i > 0) begin
        SPICLK = 1'b0;
        wait_clk(HALF);
      end
      rd = {rd[14:0], MISO};
      SPICLK = 1'b1;
      wait_clk(HALF);
      if (i == change_at) vane_code = code2;
    end
    if (raise_cs) begin
      nVaneCS = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    wait_clk(3);
    tests_run++;
    if ({MISO, MISO_nEnable, frame_done, frame_abort, bit_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL reset_vals got MISO=%b nEn=%b done=%b abort=%b cnt=%0d expected 0 1 0 0 0",
               MISO, MISO_nEnable, frame_done, frame_abort, bit_count);
    end
    nReset = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_single_frame;
    logic [15:0] rd;
    logic nen;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(12'hA5C, 16, 1'b0, -1, 12'h000, rd, nen);
    tests_run++;
    if (nen !== 1'b0) begin tests_failed++; $display("FAIL single_nen_mid got %b expected 0", nen); end
    tests_run++;
    if (rd !== 16'h0A5C) begin tests_failed++; $display("FAIL single_data got %h expected 0a5c", rd); end
    tests_run++;
    if (bit_count !== 5'd16) begin tests_failed++; $display("FAIL single_count got %0d expected 16", bit_count); end
    nVaneCS = 1'b1;
    wait_clk(HALF);
    tests_run++;
    if (MISO_nEnable !== 1'b1) begin tests_failed++; $display("FAIL single_nen_end got %b expected 1", MISO_nEnable); end
    tests_run++;
    if ((done_cnt - d0) !== 1 || (abort_cnt - a0) !== 0) begin
      tests_failed++;
      $display("FAIL single_pulses got done=%0d abort=%0d expected 1 0", done_cnt - d0, abort_cnt - a0);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd1, rd2;
    logic nen;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(12'hFFF, 16, 1'b1, -1, 12'h000, rd1, nen);
    do_frame(12'h000, 16, 1'b1, -1, 12'h000, rd2, nen);
    tests_run++;
    if (rd1 !== 16'h0FFF) begin tests_failed++; $display("FAIL b2b_first got %h expected 0fff", rd1); end
    tests_run++;
    if (rd2 !== 16'h0000) begin tests_failed++; $display("FAIL b2b_second got %h expected 0000", rd2); end
    tests_run++;
    if ((done_cnt - d0) !== 2 || (abort_cnt - a0) !== 0) begin
      tests_failed++;
      $display("FAIL b2b_pulses got done=%0d abort=%0d expected 2 0", done_cnt - d0, abort_cnt - a0);
    end
  endtask

  task automatic test_abort;
    logic [15:0] rd;
    logic nen;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(12'h3C5, 8, 1'b1, -1, 12'h000, rd, nen);
    tests_run++;
    if (rd !== 16'h0003) begin tests_failed++; $display("FAIL abort_data got %h expected 0003", rd); end
    tests_run++;
    if (bit_count !== 5'd8) begin tests_failed++; $display("FAIL abort_count got %0d expected 8", bit_count); end
    tests_run++;
    if (MISO_nEnable !== 1'b1 || MISO !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_release got nEn=%b MISO=%b expected 1 0", MISO_nEnable, MISO);
    end
    tests_run++;
    if ((done_cnt - d0) !== 0 || (abort_cnt - a0) !== 1) begin
      tests_failed++;
      $display("FAIL abort_pulses got done=%0d abort=%0d expected 0 1", done_cnt - d0, abort_cnt - a0);
    end
  endtask

  task automatic test_code_change;
    logic [15:0] rd1, rd2;
    logic nen;
    do_frame(12'h123, 16, 1'b1, 5, 12'h456, rd1, nen);
    do_frame(12'h456, 16, 1'b1, -1, 12'h000, rd2, nen);
    tests_run++;
    if (rd1 !== 16'h0123) begin tests_failed++; $display("FAIL change_first got %h expected 0123", rd1); end
    tests_run++;
    if (rd2 !== 16'h0456) begin tests_failed++; $display("FAIL change_second got %h expected 0456", rd2); end
  endtask

  task automatic test_trail;
    logic [15:0] rd;
    logic nen;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    do_frame(12'hFFF, 18, 1'b0, -1, 12'h000, rd, nen);
    tests_run++;
    if (rd !== 16'h3FFC) begin tests_failed++; $display("FAIL trail_data got %h expected 3ffc", rd); end
    tests_run++;
    if (bit_count !== 5'd18) begin tests_failed++; $display("FAIL trail_count got %0d expected 18", bit_count); end
    nVaneCS = 1'b1;
    wait_clk(HALF);
    tests_run++;
    if ((done_cnt - d0) !== 1 || (abort_cnt - a0) !== 0) begin
      tests_failed++;
      $display("FAIL trail_pulses got done=%0d abort=%0d expected 1 0", done_cnt - d0, abort_cnt - a0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] rd;
    logic nen;
    int d0, a0;
    vane_code = 12'hFFF;
    wait_clk(2);
    nVaneCS = 1'b0;
    SPICLK  = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin SPICLK = 1'b0; wait_clk(HALF); end
      SPICLK = 1'b1;
      wait_clk(HALF);
    end
    SPICLK = 1'b0;
    wait_clk(HALF);
    nReset = 1'b0;
    #1;
    tests_run++;
    if ({MISO, MISO_nEnable, frame_done, frame_abort, bit_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL midreset_vals got MISO=%b nEn=%b done=%b abort=%b cnt=%0d expected 0 1 0 0 0",
               MISO, MISO_nEnable, frame_done, frame_abort, bit_count);
    end
    wait_clk(2);
    nReset = 1'b1;
    SPICLK = 1'b1;
    wait_clk(HALF);
    tests_run++;
    if (MISO_nEnable !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_cs_low got nEn=%b expected 1", MISO_nEnable);
    end
    d0 = done_cnt; a0 = abort_cnt;
    nVaneCS = 1'b1;
    wait_clk(HALF);
    do_frame(12'h9E7, 16, 1'b1, -1, 12'h000, rd, nen);
    tests_run++;
    if (rd !== 16'h09E7) begin tests_failed++; $display("FAIL midreset_frame got %h expected 09e7", rd); end
    tests_run++;
    if ((done_cnt - d0) !== 1 || (abort_cnt - a0) !== 0) begin
      tests_failed++;
      $display("FAIL midreset_pulses got done=%0d abort=%0d expected 1 0", done_cnt - d0, abort_cnt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_code_change();
    test_trail();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
